// File: rtl/share_port_arbiter.sv
// Round-robin, frame-locked arbiter for the shared-cache write path.
// One source holds the registered shared interface until it signals done or its hold budget runs out.
module share_port_arbiter #(
  parameter  int PORT_NUB   = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int MAX_HOLD   = 15,
  localparam int WIDTH_SEL  = $clog2(PORT_NUB)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PORT_NUB-1:0]             req,
  input  logic [PORT_NUB-1:0]             in_vaild,
  input  logic [PORT_NUB-1:0]             in_done,
  input  logic [PORT_NUB*WIDTH_SEL-1:0]   in_rx_port,
  input  logic [PORT_NUB*DATA_WIDTH-1:0]  in_data,
  output logic [PORT_NUB-1:0]             grant,
  output logic                            out_vaild,
  output logic [WIDTH_SEL-1:0]            out_rx_port,
  output logic [WIDTH_SEL-1:0]            out_tx_port,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                  r_state,       w_state_nxt;
  logic [WIDTH_SEL-1:0]    r_ptr,         w_ptr_nxt;
  logic [WIDTH_SEL-1:0]    r_sel,         w_sel_nxt;
  logic [CNT_W-1:0]        r_hold_cnt,    w_hold_cnt_nxt;
  logic [PORT_NUB-1:0]     r_grant,       w_grant_nxt;
  logic                    r_out_vaild,   w_out_vaild_nxt;
  logic [WIDTH_SEL-1:0]    r_out_rx_port, w_out_rx_port_nxt;
  logic [WIDTH_SEL-1:0]    r_out_tx_port, w_out_tx_port_nxt;
  logic [DATA_WIDTH-1:0]   r_out_data,    w_out_data_nxt;
  logic                    r_timeout_err, w_timeout_err_nxt;
  logic [WIDTH_SEL-1:0]    w_winner;
  logic [WIDTH_SEL-1:0]    w_sel_inc;

  // Scan from the highest offset down so the requester closest to r_ptr is assigned last and wins.
  always_comb begin
    w_winner = r_ptr;
    for (int i = PORT_NUB - 1; i >= 0; i--) begin
      if (req[(int'(r_ptr) + i) % PORT_NUB])
        w_winner = WIDTH_SEL'((int'(r_ptr) + i) % PORT_NUB);
    end
  end

  assign w_sel_inc = (r_sel == WIDTH_SEL'(PORT_NUB - 1)) ? '0 : r_sel + 1'b1;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path through the case infers a latch.
    w_state_nxt       = r_state;
    w_ptr_nxt         = r_ptr;
    w_sel_nxt         = r_sel;
    w_hold_cnt_nxt    = r_hold_cnt;
    w_grant_nxt       = r_grant;
    w_out_vaild_nxt   = 1'b0;
    w_out_rx_port_nxt = '0;
    w_out_tx_port_nxt = '0;
    w_out_data_nxt    = '0;
    w_timeout_err_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (|req) begin
          w_grant_nxt    = PORT_NUB'(1) << w_winner;
          w_sel_nxt      = w_winner;
          w_hold_cnt_nxt = '0;
          w_state_nxt    = BUSY;
        end
      end
      BUSY: begin
        w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        if (in_vaild[r_sel]) begin
          w_out_vaild_nxt   = 1'b1;
          w_out_rx_port_nxt = in_rx_port[int'(r_sel)*WIDTH_SEL +: WIDTH_SEL];
          w_out_tx_port_nxt = r_sel;
          w_out_data_nxt    = in_data[int'(r_sel)*DATA_WIDTH +: DATA_WIDTH];
        end
        // Done takes priority: a frame ending exactly on its last allowed cycle is not an error.
        if (in_done[r_sel] || (r_hold_cnt == CNT_W'(MAX_HOLD))) begin
          w_state_nxt       = RELEASE;
          w_grant_nxt       = '0;
          w_ptr_nxt         = w_sel_inc;
          w_hold_cnt_nxt    = '0;
          w_timeout_err_nxt = ~in_done[r_sel];
        end
      end
      RELEASE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_sel         <= '0;
      r_hold_cnt    <= '0;
      r_grant       <= '0;
      r_out_vaild   <= 1'b0;
      r_out_rx_port <= '0;
      r_out_tx_port <= '0;
      r_out_data    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_sel         <= w_sel_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_grant       <= w_grant_nxt;
      r_out_vaild   <= w_out_vaild_nxt;
      r_out_rx_port <= w_out_rx_port_nxt;
      r_out_tx_port <= w_out_tx_port_nxt;
      r_out_data    <= w_out_data_nxt;
      r_timeout_err <= w_timeout_err_nxt;
    end
  end

  assign grant       = r_grant;
  assign out_vaild   = r_out_vaild;
  assign out_rx_port = r_out_rx_port;
  assign out_tx_port = r_out_tx_port;
  assign out_data    = r_out_data;
  assign busy        = (r_state != IDLE);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_share_port_arbiter.sv
// Scoreboard bench for share_port_arbiter: stimulus pushes expected forwarded words,
// a negedge monitor pops and compares them; grant/busy/timeout are checked against hand values.
module tb_share_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MH = 15;
  localparam int WS = 2;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [N-1:0]      req;
  logic [N-1:0]      in_vaild;
  logic [N-1:0]      in_done;
  logic [N*WS-1:0]   in_rx_port;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      grant;
  logic              out_vaild;
  logic [WS-1:0]     out_rx_port;
  logic [WS-1:0]     out_tx_port;
  logic [DW-1:0]     out_data;
  logic              busy;
  logic              timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*WS+DW-1:0] sb_q[$];
  logic [2*WS+DW-1:0] mon_exp;

  share_port_arbiter #(
    .PORT_NUB   (N),
    .DATA_WIDTH (DW),
    .MAX_HOLD   (MH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .in_vaild    (in_vaild),
    .in_done     (in_done),
    .in_rx_port  (in_rx_port),
    .in_data     (in_data),
    .grant       (grant),
    .out_vaild   (out_vaild),
    .out_rx_port (out_rx_port),
    .out_tx_port (out_tx_port),
    .out_data    (out_data),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each forwarded word must match the head of the scoreboard; idle outputs must be zero.
  always @(negedge clk) begin
    if (out_vaild) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got tx=%0d rx=%0d data=0x%0h, expected no word (t=%0t)",
                 out_tx_port, out_rx_port, out_data, $time);
      end else begin
        mon_exp = sb_q.pop_front();
        check("out_word", 32'({out_tx_port, out_rx_port, out_data}), 32'(mon_exp));
      end
    end else begin
      check("idle_zero", 32'({out_tx_port, out_rx_port, out_data}), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_vaild   = '0;
    in_done    = '0;
    in_rx_port = '0;
    in_data    = '0;
  endtask

  task automatic set_port(input int p, input logic v, input logic d,
                          input logic [WS-1:0] rx, input logic [DW-1:0] data);
    in_vaild[p]             = v;
    in_done[p]              = d;
    in_rx_port[p*WS +: WS]  = rx;
    in_data[p*DW +: DW]     = data;
  endtask

  // Valid and done on every port except p_keep, with recognisable junk payloads.
  task automatic noise(input int p_keep);
    for (int p = 0; p < N; p++)
      if (p != p_keep) set_port(p, 1'b1, 1'b1, WS'(3 - p), 16'hBAD0 + 16'(p));
  endtask

  // Drives n words from the granted port p starting on a BUSY cycle; w counts BUSY cycles from grant.
  task automatic run_frame(input int p, input int n, input logic [DW-1:0] base,
                           input logic [WS-1:0] rx, input bit done_last, input bit noisy);
    bit rel;
    for (int w = 0; w < n; w++) begin
      clear_inputs();
      if (noisy) noise(p);
      set_port(p, 1'b1, done_last && (w == n - 1), rx, base + DW'(w));
      sb_q.push_back({WS'(p), rx, base + DW'(w)});
      step();
      rel = (w == n - 1) && (done_last || (w == MH));
      check("grant_frame", 32'(grant), rel ? 32'd0 : (32'd1 << p));
      check("timeout_err", 32'(timeout_err), 32'((w == n - 1) && !done_last && (w == MH)));
    end
    clear_inputs();
  endtask

  // After a release: two grant-free cycles, then the expected next grant.
  task automatic gap_then(input int p_next);
    step();
    check("dead_grant", 32'(grant), 32'd0);
    check("dead_busy", 32'(busy), 32'd0);
    step();
    check("next_grant", 32'(grant), 32'd1 << p_next);
    check("next_busy", 32'(busy), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    clear_inputs();
    #2;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_vaild", 32'(out_vaild), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    req = '0;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single requester on port 2.
    req = 4'b0100;
    step();
    check("t1_grant", 32'(grant), 32'h4);
    check("t1_busy", 32'(busy), 32'd1);
    req = '0;
    run_frame(2, 4, 16'h0020, 2'd1, 1'b1, 1'b0);
    check("t1_busy_release", 32'(busy), 32'd1);
    step();
    check("t1_busy_low", 32'(busy), 32'd0);

    // Round-robin with all ports requesting.
    do_reset();
    req = 4'b1111;
    step();
    check("t2_first_grant", 32'(grant), 32'h1);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) req = '0;
      run_frame(k % 4, 2, 16'h1000 + 16'(k * 16), WS'(k), 1'b1, 1'b0);
      if (k < 4) gap_then((k + 1) % 4);
    end
    step();
    step();
    check("t2_idle", 32'(busy), 32'd0);

    // Wrap from ptr=3.
    do_reset();
    req = 4'b0100;
    step();
    check("t3_grant2", 32'(grant), 32'h4);
    req = 4'b0011;
    run_frame(2, 1, 16'h3000, 2'd0, 1'b1, 1'b0);
    gap_then(0);
    run_frame(0, 1, 16'h3100, 2'd3, 1'b1, 1'b0);
    gap_then(1);
    req = '0;
    run_frame(1, 1, 16'h3200, 2'd2, 1'b1, 1'b0);
    step();
    step();
    check("t3_idle", 32'(busy), 32'd0);

    // Timeout after 16 BUSY cycles, then done on the timeout cycle.
    do_reset();
    req = 4'b0010;
    step();
    check("t4_grant", 32'(grant), 32'h2);
    req = '0;
    run_frame(1, 16, 16'h4000, 2'd2, 1'b0, 1'b0);
    step();
    check("t4_err_pulse_end", 32'(timeout_err), 32'd0);
    check("t4_busy_low", 32'(busy), 32'd0);
    req = 4'b0010;
    step();
    check("t4b_grant", 32'(grant), 32'h2);
    req = '0;
    run_frame(1, 16, 16'h4100, 2'd2, 1'b1, 1'b0);
    step();
    check("t4b_no_err", 32'(timeout_err), 32'd0);
    step();

    // Isolation: noise on other ports while port 1 holds the grant.
    do_reset();
    req = 4'b0010;
    step();
    check("t5_grant", 32'(grant), 32'h2);
    req = 4'b1101;
    for (int c = 0; c < 2; c++) begin
      clear_inputs();
      noise(1);
      step();
      check("t5_hold_grant", 32'(grant), 32'h2);
      check("t5_no_out", 32'(out_vaild), 32'd0);
    end
    run_frame(1, 3, 16'h5000, 2'd3, 1'b1, 1'b1);
    gap_then(2);
    req = '0;
    run_frame(2, 1, 16'h5100, 2'd0, 1'b1, 1'b0);
    step();
    step();

    // Reset mid-frame with ptr=3 beforehand; ptr must restart at 0.
    req = 4'b0010;
    step();
    check("t6_grant1", 32'(grant), 32'h2);
    req = '0;
    run_frame(1, 2, 16'h6000, 2'd1, 1'b0, 1'b0);
    #5;
    rst_n = 1'b0;
    set_port(1, 1'b1, 1'b0, 2'd1, 16'h6002);
    #1;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_vaild", 32'(out_vaild), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    #1;
    rst_n = 1'b1;
    clear_inputs();
    req = 4'b1001;
    step();
    check("t6_ptr0_grant", 32'(grant), 32'h1);
    req = 4'b1000;
    run_frame(0, 1, 16'h6100, 2'd2, 1'b1, 1'b0);
    gap_then(3);
    req = '0;
    run_frame(3, 1, 16'h6200, 2'd0, 1'b1, 1'b0);
    step();
    step();
    check("t6_idle", 32'(busy), 32'd0);

    repeat (3) step();
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
